// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: base opcodes, control-sequencer states and writeback selects.
package riscv_pkg;

    localparam logic [6:0] OpRInt    = 7'b0110011;
    localparam logic [6:0] OpIInt    = 7'b0010011;
    localparam logic [6:0] OpILoad   = 7'b0000011;
    localparam logic [6:0] OpIJump   = 7'b1100111;
    localparam logic [6:0] OpSStore  = 7'b0100011;
    localparam logic [6:0] OpSBranch = 7'b1100011;
    localparam logic [6:0] OpUImm    = 7'b0110111;
    localparam logic [6:0] OpUPc     = 7'b0010111;
    localparam logic [6:0] OpUJump   = 7'b1101111;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4,
        TRAP      = 3'd5
    } ctrl_state_e;

    typedef enum logic [1:0] {
        WbAlu = 2'd0,
        WbMem = 2'd1,
        WbPc4 = 2'd2,
        WbImm = 2'd3
    } wb_sel_e;

    function automatic logic is_legal_opcode(input logic [6:0] opcode);
        case (opcode)
            OpRInt, OpIInt, OpILoad, OpIJump, OpSStore,
            OpSBranch, OpUImm, OpUPc, OpUJump: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instruction_sequencer.sv
// Multi-cycle control sequencer: drives fetch, memory, PC and register-file strobes per instruction.
// Build option SEQ_ILLEGAL_TRAP_EN: illegal opcodes lock the FSM in TRAP instead of retiring as NOPs.
module instruction_sequencer
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [6:0]      i_opcode,
    output logic            o_imem_req,
    input  logic            i_imem_ack,
    output logic            o_ir_load,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    input  logic            i_dmem_ack,
    input  logic            i_branch_taken,
    output logic            o_pc_inc,
    output logic            o_pc_load,
    output logic            o_rf_we,
    output logic [1:0]      o_wb_sel,
    output logic [2:0]      o_state,
    output logic [XLEN-1:0] o_instret,
    output logic            o_trap
);

    ctrl_state_e     state_q, state_d;
    logic [XLEN-1:0] instret_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= FETCH;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == FETCH && state_q != FETCH) begin
                instret_q <= instret_q + XLEN'(1);
            end
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        o_imem_req = 1'b0;
        o_ir_load  = 1'b0;
        o_dmem_req = 1'b0;
        o_dmem_we  = 1'b0;
        o_pc_inc   = 1'b0;
        o_pc_load  = 1'b0;
        o_rf_we    = 1'b0;
        o_wb_sel   = WbAlu;

        // Gating on rstn drops any pending request the instant reset asserts.
        if (rstn) begin
            unique case (state_q)
                FETCH: begin
                    o_imem_req = 1'b1;
                    if (i_imem_ack) begin
                        o_ir_load = 1'b1;
                        state_d   = DECODE;
                    end
                end

                DECODE: begin
                    state_d = EXECUTE;
`ifdef SEQ_ILLEGAL_TRAP_EN
                    if (!is_legal_opcode(i_opcode)) begin
                        state_d = TRAP;
                    end
`endif
                end

                EXECUTE: begin
                    case (i_opcode)
                        OpILoad, OpSStore: state_d = MEMORY;
                        OpSBranch: begin
                            o_pc_load = i_branch_taken;
                            o_pc_inc  = !i_branch_taken;
                            state_d   = FETCH;
                        end
                        default: begin
                            if (is_legal_opcode(i_opcode)) begin
                                state_d = WRITEBACK;
                            end else begin
                                // Unknown opcode retires as a NOP.
                                o_pc_inc = 1'b1;
                                state_d  = FETCH;
                            end
                        end
                    endcase
                end

                MEMORY: begin
                    o_dmem_req = 1'b1;
                    o_dmem_we  = (i_opcode == OpSStore);
                    if (i_dmem_ack) begin
                        if (i_opcode == OpSStore) begin
                            o_pc_inc = 1'b1;
                            state_d  = FETCH;
                        end else begin
                            state_d = WRITEBACK;
                        end
                    end
                end

                WRITEBACK: begin
                    o_rf_we = 1'b1;
                    state_d = FETCH;
                    case (i_opcode)
                        OpILoad:          o_wb_sel = WbMem;
                        OpUJump, OpIJump: o_wb_sel = WbPc4;
                        OpUImm:           o_wb_sel = WbImm;
                        default:          o_wb_sel = WbAlu;
                    endcase
                    if (i_opcode == OpUJump || i_opcode == OpIJump) begin
                        o_pc_load = 1'b1;
                    end else begin
                        o_pc_inc = 1'b1;
                    end
                end

                TRAP: state_d = TRAP;

                default: state_d = FETCH;
            endcase
        end
    end

    assign o_state   = state_q;
    assign o_instret = instret_q;

`ifdef SEQ_ILLEGAL_TRAP_EN
    assign o_trap = (state_q == TRAP);
`else
    assign o_trap = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench for instruction_sequencer: directed instruction vectors, strobe monitor, reset and wrap checks.
`timescale 1ns/1ps
module tb_instruction_sequencer;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [6:0]  i_opcode;
    logic        i_imem_ack, i_dmem_ack, i_branch_taken;
    logic        o_imem_req, o_ir_load, o_dmem_req, o_dmem_we;
    logic        o_pc_inc, o_pc_load, o_rf_we, o_trap;
    logic [1:0]  o_wb_sel;
    logic [2:0]  o_state;
    logic [31:0] o_instret;

    // Narrow instance that free-runs R-type instructions to exercise counter wrap.
    logic        rstn_w;
    logic        w_imem_req, w_ir_load, w_dmem_req, w_dmem_we;
    logic        w_pc_inc, w_pc_load, w_rf_we, w_trap;
    logic [1:0]  w_wb_sel;
    logic [2:0]  w_state;
    logic [3:0]  w_instret;
    logic        wrap_done = 1'b0;

    int tests  = 0;
    int failed = 0;
    logic [31:0] exp_count;

    typedef struct {
        logic [2:0]  state;
        logic        rf_we;
        logic [1:0]  wb_sel;
        logic        pc_inc;
        logic        pc_load;
        logic [31:0] instret;
    } ev_t;

    typedef struct {
        logic [6:0] op;
        int         iwait;
        bit         mem;
        int         dwait;
        logic       we;
        logic       taken;
        logic [2:0] ev_state;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       pc_inc;
        logic       pc_load;
    } vec_t;

    ev_t  sb[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    instruction_sequencer #(.XLEN(32)) dut (
        .clk(clk), .rstn(rstn), .i_opcode(i_opcode),
        .o_imem_req(o_imem_req), .i_imem_ack(i_imem_ack), .o_ir_load(o_ir_load),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .i_dmem_ack(i_dmem_ack),
        .i_branch_taken(i_branch_taken), .o_pc_inc(o_pc_inc), .o_pc_load(o_pc_load),
        .o_rf_we(o_rf_we), .o_wb_sel(o_wb_sel), .o_state(o_state),
        .o_instret(o_instret), .o_trap(o_trap)
    );

    instruction_sequencer #(.XLEN(4)) dut_w (
        .clk(clk), .rstn(rstn_w), .i_opcode(OpRInt),
        .o_imem_req(w_imem_req), .i_imem_ack(1'b1), .o_ir_load(w_ir_load),
        .o_dmem_req(w_dmem_req), .o_dmem_we(w_dmem_we), .i_dmem_ack(1'b0),
        .i_branch_taken(1'b0), .o_pc_inc(w_pc_inc), .o_pc_load(w_pc_load),
        .o_rf_we(w_rf_we), .o_wb_sel(w_wb_sel), .o_state(w_state),
        .o_instret(w_instret), .o_trap(w_trap)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [6:0] op, input int iwait, input bit mem, input int dwait,
                                input logic we, input logic taken, input ctrl_state_e ev_state,
                                input logic rf_we, input wb_sel_e wb_sel, input logic pc_inc,
                                input logic pc_load);
        vec_t v;
        v.op = op; v.iwait = iwait; v.mem = mem; v.dwait = dwait; v.we = we; v.taken = taken;
        v.ev_state = ev_state; v.rf_we = rf_we; v.wb_sel = wb_sel;
        v.pc_inc = pc_inc; v.pc_load = pc_load;
        return v;
    endfunction

    // Monitor: every cycle carrying a PC or RF strobe must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rstn && (o_pc_inc || o_pc_load || o_rf_we)) begin
            if (sb.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_strobe: state %0d inc %0b load %0b rf_we %0b, required no strobe",
                         o_state, o_pc_inc, o_pc_load, o_rf_we);
            end else begin
                ev_t e;
                e = sb.pop_front();
                check("ev_state",   o_state,   e.state);
                check("ev_rf_we",   o_rf_we,   e.rf_we);
                check("ev_wb_sel",  o_wb_sel,  e.wb_sel);
                check("ev_pc_inc",  o_pc_inc,  e.pc_inc);
                check("ev_pc_load", o_pc_load, e.pc_load);
                check("ev_instret", o_instret, e.instret);
            end
        end
    end

    // Starts and ends at 1ns after a rising edge with the DUT in FETCH.
    task automatic run_vec(input vec_t v, input bit stray);
        ev_t e;
        i_opcode = v.op;
        i_branch_taken = v.taken;
        i_imem_ack = 1'b0;
        i_dmem_ack = stray;
        e.state = v.ev_state; e.rf_we = v.rf_we; e.wb_sel = v.wb_sel;
        e.pc_inc = v.pc_inc; e.pc_load = v.pc_load; e.instret = exp_count;
        sb.push_back(e);

        for (int k = 0; k < v.iwait; k++) begin
            @(negedge clk);
            check("fetch_req", o_imem_req, 1'b1);
            check("fetch_no_ir_load", o_ir_load, 1'b0);
            tick();
        end
        i_imem_ack = 1'b1;
        @(negedge clk);
        check("ir_load", o_ir_load, 1'b1);
        tick();
        i_imem_ack = stray;
        @(negedge clk);
        check("decode_state", o_state, DECODE);
        check("decode_ir_load", o_ir_load, 1'b0);
        check("decode_imem_req", o_imem_req, 1'b0);
        tick();
        @(negedge clk);
        check("execute_state", o_state, EXECUTE);
        check("execute_dmem_req", o_dmem_req, 1'b0);
        tick();
        if (v.mem) begin
            i_dmem_ack = 1'b0;
            for (int k = 0; k < v.dwait; k++) begin
                @(negedge clk);
                check("mem_req_hold", o_dmem_req, 1'b1);
                check("mem_we", o_dmem_we, v.we);
                check("mem_state", o_state, MEMORY);
                tick();
            end
            i_dmem_ack = 1'b1;
            @(negedge clk);
            check("mem_req_ack", o_dmem_req, 1'b1);
            check("mem_we_ack", o_dmem_we, v.we);
            tick();
            i_dmem_ack = 1'b0;
        end
        if (v.ev_state == WRITEBACK) begin
            @(negedge clk);
            check("wb_state", o_state, WRITEBACK);
            check("wb_dmem_req", o_dmem_req, 1'b0);
            tick();
        end
        i_imem_ack = 1'b0;
        i_dmem_ack = 1'b0;
        @(negedge clk);
        check("back_to_fetch", o_state, FETCH);
        check("instret_after", o_instret, exp_count + 32'd1);
        exp_count = exp_count + 32'd1;
        tick();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        i_imem_ack = 1'b0;
        i_dmem_ack = 1'b0;
        @(negedge clk);
        check("rst_state", o_state, FETCH);
        check("rst_trap", o_trap, 1'b0);
        check("rst_instret", o_instret, 32'd0);
        check("rst_imem_req", o_imem_req, 1'b0);
        @(posedge clk);
        #1 rstn = 1'b1;
        exp_count = 32'd0;
        @(negedge clk);
        check("rel_imem_req", o_imem_req, 1'b1);
        tick();
    endtask

`ifdef SEQ_ILLEGAL_TRAP_EN
    task automatic trap_test();
        i_opcode = 7'h7F;
        i_imem_ack = 1'b1;
        @(negedge clk);
        check("trap_ir_load", o_ir_load, 1'b1);
        tick();
        i_imem_ack = 1'b0;
        @(negedge clk);
        check("trap_decode", o_state, DECODE);
        tick();
        i_imem_ack = 1'b1;
        i_dmem_ack = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            check("trap_state", o_state, TRAP);
            check("trap_flag", o_trap, 1'b1);
            check("trap_imem_req", o_imem_req, 1'b0);
            check("trap_dmem_req", o_dmem_req, 1'b0);
            tick();
        end
        check("trap_instret", o_instret, exp_count);
        i_imem_ack = 1'b0;
        i_dmem_ack = 1'b0;
    endtask
`endif

    task automatic mem_reset_test();
        i_opcode = OpILoad;
        i_imem_ack = 1'b1;
        @(negedge clk);
        check("mr_ir_load", o_ir_load, 1'b1);
        tick();
        i_imem_ack = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("mr_dmem_req", o_dmem_req, 1'b1);
        #2 rstn = 1'b0;
        #1;
        check("mr_dmem_req_async", o_dmem_req, 1'b0);
        check("mr_state", o_state, FETCH);
        check("mr_instret", o_instret, 32'd0);
        check("mr_imem_req", o_imem_req, 1'b0);
        check("mr_ir_load_off", o_ir_load, 1'b0);
        @(posedge clk);
        #1 rstn = 1'b1;
        exp_count = 32'd0;
        @(negedge clk);
        check("mr_first_req", o_imem_req, 1'b1);
        tick();
    endtask

    // Wrap: the 4-bit instance must roll 4'hF -> 0 on the next retire.
    initial begin
        rstn_w = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn_w = 1'b1;
        for (int k = 0; k < 200 && w_instret != 4'hF; k++) @(negedge clk);
        check("wrap_reach_max", w_instret, 4'hF);
        for (int k = 0; k < 10 && w_instret == 4'hF; k++) @(negedge clk);
        check("wrap_to_zero", w_instret, 4'h0);
        wrap_done = 1'b1;
    end

    initial begin
        rstn = 1'b0;
        i_opcode = 7'd0;
        i_imem_ack = 1'b0;
        i_dmem_ack = 1'b0;
        i_branch_taken = 1'b0;
        exp_count = 32'd0;

        //           op         iw mem dw we tk  event      rf  wb     inc ld
        vecs.push_back(mk(OpRInt,    3, 0, 0, 0, 0, WRITEBACK, 1, WbAlu, 1, 0));
        vecs.push_back(mk(OpILoad,   0, 1, 5, 0, 0, WRITEBACK, 1, WbMem, 1, 0));
        vecs.push_back(mk(OpSStore,  1, 1, 2, 1, 0, MEMORY,    0, WbAlu, 1, 0));
        vecs.push_back(mk(OpSBranch, 0, 0, 0, 0, 1, EXECUTE,   0, WbAlu, 0, 1));
        vecs.push_back(mk(OpSBranch, 2, 0, 0, 0, 0, EXECUTE,   0, WbAlu, 1, 0));
        vecs.push_back(mk(OpUJump,   0, 0, 0, 0, 0, WRITEBACK, 1, WbPc4, 0, 1));
        vecs.push_back(mk(OpIJump,   1, 0, 0, 0, 1, WRITEBACK, 1, WbPc4, 0, 1));
        vecs.push_back(mk(OpUImm,    0, 0, 0, 0, 0, WRITEBACK, 1, WbImm, 1, 0));
        vecs.push_back(mk(OpUPc,     0, 0, 0, 0, 0, WRITEBACK, 1, WbAlu, 1, 0));
        vecs.push_back(mk(OpIInt,    1, 0, 0, 0, 0, WRITEBACK, 1, WbAlu, 1, 0));
`ifndef SEQ_ILLEGAL_TRAP_EN
        vecs.push_back(mk(7'h7F,     0, 0, 0, 0, 0, EXECUTE,   0, WbAlu, 1, 0));
`endif

        repeat (2) @(negedge clk);
        check("init_state", o_state, FETCH);
        check("init_instret", o_instret, 32'd0);
        check("init_trap", o_trap, 1'b0);
        check("init_imem_req", o_imem_req, 1'b0);
        check("init_dmem_req", o_dmem_req, 1'b0);
        check("init_strobes", {o_ir_load, o_pc_inc, o_pc_load, o_rf_we}, 4'b0000);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("init_first_req", o_imem_req, 1'b1);
        tick();

        foreach (vecs[i]) run_vec(vecs[i], (i == 0));
`ifdef SEQ_ILLEGAL_TRAP_EN
        trap_test();
`endif
        do_reset();
        run_vec(vecs[0], 1'b0);
        mem_reset_test();
        run_vec(vecs[0], 1'b0);

        for (int k = 0; k < 1000 && !wrap_done; k++) @(negedge clk);
        check("wrap_finished", wrap_done, 1'b1);
        check("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
